data_mem_stage: RTL and testbench

//   MEM-stage data memory: consumes the ALU result (BusW) as a byte address and

---
 rtl/data_mem_stage.sv | 119 +++++++++++
 tb/tb_data_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// MEM-stage data memory: 64-bit LDUR/STUR on an internal doubleword array with a
// fixed multi-cycle latency, a Busy stall while a request is held, and a Done pulse.
module data_mem_stage #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        ResetL,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrFault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            flt_q, flt_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     mem_q [DEPTH];

  logic            req;
  logic            fault;
  logic            mem_we;
  logic [AW-1:0]   idx_in;

  assign req    = MemRead | MemWrite;
  assign idx_in = Address[AW+2:3];
  assign fault  = (MemRead & MemWrite) | (Address[2:0] != 3'd0) |
                  (Address[63:3] >= 61'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    Busy    = 1'b0;
    case (state_q)
      // RESP accepts the next instruction exactly like IDLE, but never stalls.
      IDLE, RESP: begin
        if (req) begin
          Busy = (state_q == IDLE);
          if (fault) begin
            state_d = RESP;
            flt_d   = 1'b1;
            rdata_d = 64'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
            wr_d    = MemWrite;
            flt_d   = 1'b0;
            idx_d   = idx_in;
            wdata_d = WriteData;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        Busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = mem_q[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Done      = (state_q == RESP);
  assign AddrFault = (state_q == RESP) & flt_q;
  assign ReadData  = rdata_q;

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request payload needs no reset: it is only consumed from WAIT.
  always_ff @(posedge Clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // The array is deliberately outside reset so contents survive ResetL.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized bench for data_mem_stage against a transaction-level memory model.
module tb_data_mem_stage;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        Clk = 1'b0;
  logic        ResetL;
  logic        MemRead, MemWrite;
  logic [63:0] Address, WriteData;
  logic [63:0] ReadData;
  logic        Busy, Done, AddrFault;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl_mem [DEPTH];
  logic [63:0] mdl_rd;

  data_mem_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clk(Clk), .ResetL(ResetL), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .AddrFault(AddrFault)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request from presentation to Done; optionally presents the next request in the Done cycle.
  task automatic run_txn(input string nm, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input bit chained, input bit chain_next,
                         input logic nrd, input logic nwr,
                         input logic [63:0] naddr, input logic [63:0] nwd);
    bit          f;
    int          exp_k;
    int          idx;
    logic [63:0] exp_rd;
    f     = (rd && wr) || (addr % 8 != 0) || (addr / 8 >= 64'(DEPTH));
    exp_k = f ? 1 : LATENCY + 1;
    idx   = f ? 0 : int'(addr / 8);
    if (!chained) begin
      @(negedge Clk);
      MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd;
      #1;
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", nm, Busy, Done);
      end
    end
    for (int k = 1; k <= exp_k; k++) begin
      @(posedge Clk); #1;
      if (k == 1) begin MemRead = 1'b0; MemWrite = 1'b0; end
      @(negedge Clk);
      if (k < exp_k) begin
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
          errors++;
          $display("FAIL %s wait%0d: busy=%b done=%b, required busy=1 done=0", nm, k, Busy, Done);
        end
      end else begin
        if (f)       exp_rd = 64'd0;
        else if (rd) exp_rd = mdl_mem[idx];
        else         exp_rd = mdl_rd;
        if (!f && wr) mdl_mem[idx] = wd;
        mdl_rd = exp_rd;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b1 || AddrFault !== f) begin
          errors++;
          $display("FAIL %s done: busy=%b done=%b fault=%b, required busy=0 done=1 fault=%b",
                   nm, Busy, Done, AddrFault, f);
        end
        checks++;
        if (ReadData !== exp_rd) begin
          errors++;
          $display("FAIL %s rdata: got %h, required %h", nm, ReadData, exp_rd);
        end
      end
    end
    if (chain_next) begin
      MemRead = nrd; MemWrite = nwr; Address = naddr; WriteData = nwd;
    end
  endtask

  task automatic txn(input string nm, input logic rd, input logic wr,
                     input logic [63:0] addr, input logic [63:0] wd);
    run_txn(nm, rd, wr, addr, wd, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic check_outputs_reset(input string nm);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || AddrFault !== 1'b0 || ReadData !== 64'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b fault=%b rdata=%h, required all zero",
               nm, Busy, Done, AddrFault, ReadData);
    end
  endtask

  task automatic test_reset();
    ResetL = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); ResetL = 1'b1; mdl_rd = 64'd0;
    txn("rst_st", 1'b0, 1'b1, 64'h28, 64'hA5A5_5A5A_0123_4567);
    txn("rst_ld", 1'b1, 1'b0, 64'h28, 64'd0);
    #2 ResetL = 1'b0;
    #1 check_outputs_reset("async_reset");
    @(negedge Clk); ResetL = 1'b1; mdl_rd = 64'd0;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < DEPTH; i++)
      txn("fill", 1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom});
  endtask

  task automatic test_store_load();
    txn("st10", 1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
    txn("ld10", 1'b1, 1'b0, 64'h10, 64'd0);
    checks++;
    if (ReadData !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL ld10_const: got %h, required deadbeefcafef00d", ReadData);
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_st", 1'b0, 1'b1, 64'h08, 64'h0BAD_F00D_1234_5678,
            1'b0, 1'b1, 1'b1, 1'b0, 64'h08, 64'd0);
    run_txn("b2b_ld", 1'b1, 1'b0, 64'h08, 64'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic test_misaligned();
    txn("mis14", 1'b1, 1'b0, 64'h14, 64'd0);
    txn("ld10_after", 1'b1, 1'b0, 64'h10, 64'd0);
  endtask

  task automatic test_range_fault();
    txn("oor200", 1'b1, 1'b0, 64'h200, 64'd0);
    txn("both0", 1'b1, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    txn("ld0", 1'b1, 1'b0, 64'h0, 64'd0);
  endtask

  task automatic test_reset_wait();
    txn("st18_old", 1'b0, 1'b1, 64'h18, 64'h2222);
    @(negedge Clk);
    MemRead = 1'b0; MemWrite = 1'b1; Address = 64'h18; WriteData = 64'h1111;
    @(posedge Clk); #1;
    MemWrite = 1'b0;
    #1 ResetL = 1'b0;
    #1 check_outputs_reset("reset_in_wait");
    @(negedge Clk); ResetL = 1'b1; mdl_rd = 64'd0;
    txn("ld18", 1'b1, 1'b0, 64'h18, 64'd0);
  endtask

  task automatic gen_op(output logic rd, output logic wr,
                        output logic [63:0] addr, output logic [63:0] wd);
    int mode;
    mode = $urandom_range(0, 9);
    rd   = $urandom_range(0, 1);
    wr   = !rd;
    wd   = {$urandom, $urandom};
    addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
    case (mode)
      0: addr = addr | 64'($urandom_range(1, 7));
      1: addr = ({$urandom, $urandom} & ~64'h7) | 64'h1000;
      2: begin rd = 1'b1; wr = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic test_random();
    logic rd, wr, nrd, nwr;
    logic [63:0] addr, wd, naddr, nwd;
    bit prev_ch, ch;
    prev_ch = 1'b0;
    gen_op(rd, wr, addr, wd);
    for (int i = 0; i < 200; i++) begin
      gen_op(nrd, nwr, naddr, nwd);
      ch = (i < 199) ? bit'($urandom_range(0, 1)) : 1'b0;
      run_txn("rand", rd, wr, addr, wd, prev_ch, ch, nrd, nwr, naddr, nwd);
      prev_ch = ch;
      rd = nrd; wr = nwr; addr = naddr; wd = nwd;
    end
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_range_fault();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
